// File: rtl/register_file.sv
// Register file: 2**ADDR_W entries of DATA_W bits.
// It has two combinational read ports and one write port.
// Entry 0 is hard-wired to zero, and a write to it is dropped.
// Reads see only committed state; a read and a write to the same
// entry in one cycle returns the old value until the clock edge.
// wr_count counts committed writes since the last reset and wraps
// silently at 16 bits.
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_wr_en,
   input  logic [ADDR_W-1:0] reg_wr_addr,
   input  logic [DATA_W-1:0] reg_wr_data,
   input  logic [ADDR_W-1:0] rd_addr_0,
   input  logic [ADDR_W-1:0] rd_addr_1,
   output logic [DATA_W-1:0] rd_data_0,
   output logic [DATA_W-1:0] rd_data_1,
   output logic [15:0]       wr_count
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              commit;

   // A write commits only when enabled and aimed at a non-zero entry.
   // The reset check is handled by the sequential block, where rst has priority.
   assign commit = reg_wr_en && (reg_wr_addr != '0);

   // Storage update: reset clears every entry, otherwise a committed write lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (commit) begin
         mem[reg_wr_addr] <= reg_wr_data;
      end
   end

   // Committed-write counter; the 16-bit wrap is plain modular overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count <= '0;
      end else if (commit) begin
         wr_count <= wr_count + 16'd1;
      end
   end

   // Read ports: zero-latency lookup, with entry 0 forced to zero.
   always_comb begin
      rd_data_0 = '0;
      rd_data_1 = '0;
      if (rd_addr_0 != '0) rd_data_0 = mem[rd_addr_0];
      if (rd_addr_1 != '0) rd_data_1 = mem[rd_addr_1];
   end

endmodule
